// File: rtl/y_zigzag_rle.sv
// y_zigzag_rle: zigzag scan of one quantized 8x8 luma block into DC-diff, AC run/size/amp, ZRL and EOB symbols.
module y_zigzag_rle #(
  parameter int DATA_W = 11
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable,
  input  logic [0:7][0:7][DATA_W-1:0]    Q,
  input  logic                           dc_clear,
  output logic                           busy,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           out_is_dc,
  output logic [3:0]                     out_run,
  output logic [3:0]                     out_size,
  output logic [DATA_W-1:0]              out_amp,
  output logic                           out_eob,
  output logic                           out_zrl,
  output logic                           block_done
);
  typedef enum logic [2:0] {IDLE, DC, SCAN, EMIT, ZRL, EOB} state_t;
  localparam logic [5:0] zz [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63};
  localparam int SYM_W = DATA_W + 12;
  function automatic logic [3:0] size_of(input logic signed [DATA_W:0] v);
    logic [DATA_W:0] m;
    logic [3:0] s;
    m = v[DATA_W] ? -v : v;
    s = '0;
    for (int i = 0; i <= DATA_W; i++) if (m[i]) s = 4'(i + 1);
    return s;
  endfunction
  // negative values become (v-1) truncated to size bits, i.e. one's complement of |v|
  function automatic logic [DATA_W-1:0] amp_of(input logic signed [DATA_W:0] v, input logic [3:0] s);
    logic [DATA_W:0] t;
    t = v[DATA_W] ? v - (DATA_W+1)'(1) : v;
    for (int i = 0; i <= DATA_W; i++) if (i >= int'(s)) t[i] = 1'b0;
    return t[DATA_W-1:0];
  endfunction
  state_t                  r_state, w_state;
  logic [5:0]              r_k, w_k, r_run, w_run;
  logic [DATA_W-1:0]       r_pred, w_pred, w_pred_eff;
  logic [DATA_W-1:0]       r_blk [64];
  logic signed [DATA_W:0]  w_diff, w_ac;
  logic [3:0]              w_dc_size, w_ac_size;
  logic                    w_xfer, w_cap, w_done, w_busy;
  logic [SYM_W-1:0]        w_sym;
  assign w_xfer     = out_valid & out_ready;
  assign w_pred_eff = dc_clear ? '0 : r_pred;
  assign w_diff     = {Q[0][0][DATA_W-1], Q[0][0]} - {w_pred_eff[DATA_W-1], w_pred_eff};
  assign w_ac       = {r_blk[r_k][DATA_W-1], r_blk[r_k]};
  assign w_dc_size  = size_of(w_diff);
  assign w_ac_size  = size_of(w_ac);
  // w_sym packs {valid, is_dc, run, size, amp, eob, zrl}
  always_comb begin
    w_state = r_state;
    w_k     = r_k;
    w_run   = r_run;
    w_pred  = w_pred_eff;
    w_cap   = 1'b0;
    w_done  = 1'b0;
    w_busy  = busy;
    w_sym   = {out_valid, out_is_dc, out_run, out_size, out_amp, out_eob, out_zrl};
    case (r_state)
      IDLE: if (enable) begin
        w_cap   = 1'b1;
        w_pred  = Q[0][0];
        w_state = DC;
        w_busy  = 1'b1;
        w_sym   = {2'b11, 4'd0, w_dc_size, amp_of(w_diff, w_dc_size), 2'b00};
      end
      DC: if (w_xfer) begin
        w_state = SCAN;
        w_k     = 6'd1;
        w_run   = '0;
      end
      SCAN: if (r_blk[r_k] == '0) begin
        if (r_k == 6'd63) begin
          w_state = EOB;
          w_sym   = {2'b10, 4'd0, 4'd0, {DATA_W{1'b0}}, 2'b10};
        end else begin
          w_run = r_run + 6'd1;
          w_k   = r_k + 6'd1;
        end
      end else if (r_run >= 6'd16) begin
        w_state = ZRL;
        w_sym   = {2'b10, 4'd15, 4'd0, {DATA_W{1'b0}}, 2'b01};
      end else begin
        w_state = EMIT;
        w_sym   = {2'b10, r_run[3:0], w_ac_size, amp_of(w_ac, w_ac_size), 2'b00};
      end
      ZRL: if (w_xfer) begin
        w_state = SCAN;
        w_run   = r_run - 6'd16;
      end
      EMIT: if (w_xfer) begin
        w_run   = '0;
        w_k     = r_k + 6'd1;
        w_done  = r_k == 6'd63;
        w_state = r_k == 6'd63 ? IDLE : SCAN;
      end
      EOB: if (w_xfer) begin
        w_state = IDLE;
        w_done  = 1'b1;
      end
      default: w_state = IDLE;
    endcase
    if (w_xfer) w_sym = '0;
    if (w_done) w_busy = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_k        <= '0;
      r_run      <= '0;
      r_pred     <= '0;
      busy       <= 1'b0;
      block_done <= 1'b0;
      {out_valid, out_is_dc, out_run, out_size, out_amp, out_eob, out_zrl} <= '0;
    end else begin
      r_state    <= w_state;
      r_k        <= w_k;
      r_run      <= w_run;
      r_pred     <= w_pred;
      busy       <= w_busy;
      block_done <= w_done;
      {out_valid, out_is_dc, out_run, out_size, out_amp, out_eob, out_zrl} <= w_sym;
    end
  end
  // block is stored already in zigzag order so the scan indexes it linearly
  always_ff @(posedge clk) begin
    if (w_cap) for (int i = 0; i < 64; i++) r_blk[i] <= Q[zz[i][5:3]][zz[i][2:0]];
  end
endmodule

// File: tb/tb_y_zigzag_rle.sv
// tb_y_zigzag_rle: randomized and directed checks of y_zigzag_rle against a symbol-list reference model.
module tb_y_zigzag_rle;
  localparam int DW = 11;
  logic                      clk = 1'b0;
  logic                      rst = 1'b0;
  logic                      enable = 1'b0;
  logic                      dc_clear = 1'b0;
  logic                      out_ready = 1'b0;
  logic [0:7][0:7][DW-1:0]   q = '0;
  logic                      busy, out_valid, out_is_dc, out_eob, out_zrl, block_done;
  logic [3:0]                out_run, out_size;
  logic [DW-1:0]             out_amp;
  typedef struct packed {
    logic          dc;
    logic [3:0]    run;
    logic [3:0]    size;
    logic [DW-1:0] amp;
    logic          eob;
    logic          zrl;
  } sym_t;
  sym_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   pred_m = 0;
  int   zr[64], zc[64];
  int   blk[8][8];
  int   dcyc;
  y_zigzag_rle #(.DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .Q(q), .dc_clear(dc_clear),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .out_is_dc(out_is_dc),
    .out_run(out_run), .out_size(out_size), .out_amp(out_amp), .out_eob(out_eob),
    .out_zrl(out_zrl), .block_done(block_done)
  );
  always #5 clk = ~clk;
  function automatic int bits_of(int v);
    int m = v < 0 ? -v : v;
    int s = 0;
    while (m > 0) begin s++; m = m >> 1; end
    return s;
  endfunction
  function automatic sym_t mk(bit dc, int run, int v, bit eob, bit zrl);
    sym_t s;
    int n = bits_of(v);
    s.dc = dc; s.run = 4'(run); s.size = 4'(n);
    s.amp = DW'(v >= 0 ? v : (v - 1) & ((1 << n) - 1));
    s.eob = eob; s.zrl = zrl;
    return s;
  endfunction
  function automatic void build_zigzag();
    int n = 0;
    for (int s = 0; s < 15; s++)
      for (int i = 0; i < 8; i++) begin
        int r = (s % 2 == 0) ? ((s < 8 ? s : 7) - i) : ((s < 8 ? 0 : s - 7) + i);
        int c = s - r;
        if (r >= 0 && r < 8 && c >= 0 && c < 8) begin zr[n] = r; zc[n] = c; n++; end
      end
  endfunction
  function automatic void model(bit clr);
    int run = 0;
    if (clr) pred_m = 0;
    exp_q.delete();
    exp_q.push_back(mk(1, 0, blk[0][0] - pred_m, 0, 0));
    pred_m = blk[0][0];
    for (int k = 1; k < 64; k++) begin
      int v = blk[zr[k]][zc[k]];
      if (v == 0) run++;
      else begin
        while (run >= 16) begin exp_q.push_back(mk(0, 15, 0, 0, 1)); run -= 16; end
        exp_q.push_back(mk(0, run, v, 0, 0));
        run = 0;
      end
    end
    if (blk[7][7] == 0) exp_q.push_back(mk(0, 0, 0, 1, 0));
  endfunction
  task automatic clear_blk();
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) blk[r][c] = 0;
  endtask
  task automatic rand_blk(int pct);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        blk[r][c] = ($urandom_range(99) < pct) ? int'($urandom_range(2047)) - 1024 : 0;
  endtask
  task automatic send_block(input bit clr, input bit rnd, input bit poke, input bit chain,
                            input int abort_at, output int done_cyc);
    int   n;
    bit   xfer_prev;
    sym_t o;
    model(clr);
    if (!chain) begin @(posedge clk); #1; end
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) q[r][c] = DW'(blk[r][c]);
    enable = 1'b1;
    dc_clear = clr;
    out_ready = rnd ? 1'($urandom_range(1)) : 1'b1;
    @(posedge clk); #1;
    enable = 1'b0;
    dc_clear = 1'b0;
    n = 0;
    done_cyc = -1;
    xfer_prev = 1'b0;
    while (n < 3000 && done_cyc < 0) begin
      @(negedge clk);
      if (n == 0) begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL busy_cycle0: got %b want 1", busy); end
      end
      if (abort_at == n) begin
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, out_valid, out_is_dc, out_run, out_size, out_amp, out_eob, out_zrl, block_done} !== '0) begin
          errors++;
          $display("FAIL reset_mid_outputs: got busy=%b valid=%b done=%b run=%0d size=%0d amp=%0h want all 0",
                   busy, out_valid, block_done, out_run, out_size, out_amp);
        end
        pred_m = 0;
        exp_q.delete();
        done_cyc = n;
        return;
      end
      if (xfer_prev) begin
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL no_back_to_back: got valid=%b want 0", out_valid); end
      end
      if (out_valid === 1'b1) begin
        o = {out_is_dc, out_run, out_size, out_amp, out_eob, out_zrl};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_symbol: got dc=%b run=%0d size=%0d amp=%0h eob=%b zrl=%b want none",
                   o.dc, o.run, o.size, o.amp, o.eob, o.zrl);
        end else if (o !== exp_q[0]) begin
          errors++;
          $display("FAIL symbol: got dc=%b run=%0d size=%0d amp=%0h eob=%b zrl=%b want dc=%b run=%0d size=%0d amp=%0h eob=%b zrl=%b",
                   o.dc, o.run, o.size, o.amp, o.eob, o.zrl,
                   exp_q[0].dc, exp_q[0].run, exp_q[0].size, exp_q[0].amp, exp_q[0].eob, exp_q[0].zrl);
        end
        xfer_prev = out_ready;
        if (out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      end else xfer_prev = 1'b0;
      if (block_done === 1'b1) begin
        checks++;
        if (exp_q.size() != 0 || busy !== 1'b0) begin
          errors++;
          $display("FAIL block_done: got %0d symbols missing, busy=%b want 0 missing, busy=0", exp_q.size(), busy);
        end
        done_cyc = n;
      end else begin
        enable = poke && busy && ($urandom_range(2) == 0);
        if (enable) for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) q[r][c] = DW'($urandom);
        @(posedge clk); #1;
        enable = 1'b0;
        n++;
        out_ready = rnd ? 1'($urandom_range(1)) : 1'b1;
      end
    end
    if (done_cyc < 0) begin
      checks++;
      errors++;
      $display("FAIL block_timeout: got no block_done in %0d cycles want one", n);
    end
  endtask
  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, out_valid, out_is_dc, out_run, out_size, out_amp, out_eob, out_zrl, block_done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b valid=%b done=%b want all 0", busy, out_valid, block_done);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    pred_m = 0;
  endtask
  task automatic test_all_zero();
    clear_blk();
    send_block(1'b0, 1'b0, 1'b0, 1'b0, -1, dcyc);
    checks++;
    if (dcyc != 65) begin errors++; $display("FAIL all_zero_done_cycle: got %0d want 65", dcyc); end
  endtask
  task automatic test_dc_max();
    clear_blk();
    blk[0][0] = 1023;
    send_block(1'b0, 1'b0, 1'b0, 1'b0, -1, dcyc);
    send_block(1'b0, 1'b0, 1'b0, 1'b0, -1, dcyc);
  endtask
  task automatic test_negative();
    clear_blk();
    blk[0][0] = -5;
    blk[0][1] = -1;
    send_block(1'b1, 1'b0, 1'b0, 1'b0, -1, dcyc);
  endtask
  task automatic test_zrl();
    clear_blk();
    blk[zr[18]][zc[18]] = 7;
    send_block(1'b0, 1'b0, 1'b0, 1'b0, -1, dcyc);
  endtask
  task automatic test_last();
    clear_blk();
    blk[7][7] = -1024;
    send_block(1'b0, 1'b0, 1'b0, 1'b0, -1, dcyc);
  endtask
  task automatic test_backpressure();
    for (int i = 0; i < 8; i++) begin
      rand_blk(i < 2 ? 90 : 12);
      send_block(1'($urandom_range(1)), 1'b1, 1'b0, 1'b0, -1, dcyc);
    end
  endtask
  task automatic test_enable_busy();
    for (int i = 0; i < 3; i++) begin
      rand_blk(20);
      send_block(1'b0, 1'b1, 1'b1, 1'b0, -1, dcyc);
    end
  endtask
  task automatic test_back_to_back();
    rand_blk(15);
    send_block(1'b0, 1'b0, 1'b0, 1'b0, -1, dcyc);
    for (int i = 0; i < 3; i++) begin
      rand_blk(15);
      send_block(1'b0, 1'($urandom_range(1)), 1'b0, 1'b1, -1, dcyc);
    end
  endtask
  task automatic test_reset_mid();
    rand_blk(30);
    blk[0][0] = 777;
    send_block(1'b0, 1'b1, 1'b0, 1'b0, 20, dcyc);
    clear_blk();
    blk[0][0] = 300;
    blk[2][3] = -17;
    send_block(1'b0, 1'b0, 1'b0, 1'b0, -1, dcyc);
  endtask
  initial begin
    build_zigzag();
    test_reset();
    test_all_zero();
    test_dc_max();
    test_negative();
    test_zrl();
    test_last();
    test_backpressure();
    test_enable_busy();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/y_zigzag_rle.md
# y_zigzag_rle

Luma entropy-prep stage directly downstream of the Y quantizer. Accepts one quantized 8x8 block as a parallel matrix on an `enable` pulse. Scans it in JPEG zigzag order and emits a serial stream of (run, size, amplitude) symbols: one differentially coded DC symbol, AC run-length symbols, ZRL and EOB markers. The stream feeds the Huffman encoder through a valid/ready handshake.

## Interface
- `DATA_W`, 11: coefficient width (signed, range -1024..1023).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-low reset.
- `enable` in 1: one-cycle pulse; `Q` holds a valid block this cycle.
- `Q[0:7][0:7]` in `DATA_W` each: signed quantized coefficients, [row][col].
- `dc_clear` in 1: synchronous clear of the DC predictor (image/restart boundary).
- `busy` out 1: block captured and not yet finished.
- `out_valid` out 1: symbol valid.
- `out_ready` in 1: consumer accepts symbol.
- `out_is_dc` out 1: symbol is the DC symbol.
- `out_run` out 4: AC zero run, 0..15.
- `out_size` out 4: magnitude category, 0..11.
- `out_amp` out 11: amplitude bits; low `out_size` bits are valid, the upper bits are 0.
- `out_eob` out 1: symbol is EOB (run 0, size 0).
- `out_zrl` out 1: symbol is ZRL (run 15, size 0).
- `block_done` out 1: one-cycle pulse after the last symbol of a block is accepted.

## Operation
- States: IDLE, DC, SCAN, EMIT, ZRL, EOB.
- IDLE:
  - `enable`=1 latches all 64 coefficients into an internal block register.
  - Computes DC `diff = sext12(Q[0][0]) - pred` and sets `pred <= Q[0][0]`.
  - Transitions to DC.
  - `enable` is ignored in every state except IDLE.
- `dc_clear`:
  - Sets `pred` to 0.
  - If asserted together with an accepted `enable`, that block's diff uses `pred`=0 and `pred` then takes `Q[0][0]`.
- DC: presents the DC symbol (`out_is_dc`=1, run 0). On handshake goes to SCAN with `k`=1 and `run`=0.
- Zigzag order is the standard JPEG table over [row][col]: (0,0),(0,1),(1,0),(2,0),(1,1),(0,2),(0,3),(1,2),… ending at (7,7). `k` is the zigzag index, 0..63.
- SCAN, one coefficient `c = zz[k]` per cycle:
  - `c`=0 and `k`<63: `run++`, `k++`.
  - `c`=0 and `k`=63: load EOB, go to EOB.
  - `c`≠0 and `run`≥16: load ZRL, go to ZRL. On handshake `run -= 16`, return to SCAN with the same `k`.
  - `c`≠0 and `run`<16: load (run, size, amp), go to EMIT. On handshake `run`=0; if `k`=63 the block is done, else `k++` and return to SCAN.
- ZRLs are only issued before a nonzero coefficient; trailing zeros produce exactly one EOB and no ZRL.
- A block whose zz[63]≠0 has no EOB.
- Size: bit length of |v|, with 0 mapping to 0. DC diff spans -2047..2047 and AC spans -1024..1023, so the maximum size is 11 in both cases.
- Amplitude: `v`≥0 gives `v`; `v`<0 gives `(v-1)` masked to `size` bits, i.e. the one's complement of |v|.
- Done: after the final handshake the block goes to IDLE, `busy`=0, and `block_done`=1 for one cycle. A new `enable` is accepted in that same cycle.

## Timing
- Reset (`rst`=0 at an edge):
  - State IDLE, and `pred`, `k`, `run` cleared to 0.
  - All outputs 0: `busy`, `out_valid`, `out_is_dc`, `out_run`, `out_size`, `out_amp`, `out_eob`, `out_zrl`, `block_done`.
  - Reset mid-block abandons the block immediately with no further symbols.
- Outputs are registered.
- Cycle numbering: E0 is the edge capturing `enable`; "cycle n" is the interval after edge En.
- Latency: `busy`=1 and `out_valid`=1 with the DC symbol in cycle 0.
- Handshake: a transfer occurs at an edge with `out_valid`&&`out_ready`=1.
  - While `out_valid`=1 and `out_ready`=0, all `out_*` are held stable and the scan is frozen.
  - `out_valid` drops in the cycle after the transfer; there are no back-to-back symbols.
- Throughput: each zero coefficient costs 1 cycle; each emitted symbol costs 2 cycles minimum.
- All-zero block, `out_ready`=1:
  - DC transfers at E1.
  - SCAN runs at E2..E64.
  - EOB is valid in cycle 64 and transfers at E65.
  - `block_done`=1 in cycle 65.

## Test plan
- All-zero block after reset, `out_ready`=1 → DC (size 0, amp 0), then EOB. `block_done` in cycle 65, `busy` low in cycle 65.
- Two blocks with `Q[0][0]`=1023, others 0 → first DC size 10, amp 1023; second DC size 0, amp 0.
- Negative values: `dc_clear`, then `Q[0][0]`=-5 and `Q[0][1]`=-1 → DC size 3, amp 3'b010; AC (run 0, size 1, amp 0); then EOB.
- Run-length/ZRL: only zz[18]=7 → DC size 0; ZRL (run 15, size 0); (run 1, size 3, amp 7); EOB.
- Last coefficient only, `Q[7][7]`=-1024 → DC; three ZRLs; (run 14, size 11, amp 1023); no EOB; `block_done` after that symbol.
- Backpressure and robustness:
  - Random `out_ready` gives a symbol stream identical to the `out_ready`=1 case, with `out_*` stable during stalls.
  - `enable` while `busy` is ignored.
  - `rst` low mid-scan: all outputs are 0 the next cycle; the following block's DC uses `pred`=0.
